// File: rtl/dac_tlv5618_multi_loader_if.sv
// dac_tlv5618_multi_loader_if
// Request/status and serial DAC bus bundle for the TLV5618 loader.
interface dac_tlv5618_multi_loader_if #(
  parameter int NUM_DEV    = 2,
  parameter int DATA_WIDTH = 12
);
  logic                            PowerDown;
  logic                            Speed;
  logic [NUM_DEV*2*DATA_WIDTH-1:0] DacData;
  logic [NUM_DEV*2-1:0]            LoadMask;
  logic                            LoadStart;
  logic                            Busy;
  logic                            LoadDone;
  logic                            Overrun;
  logic [NUM_DEV-1:0]              nCS;
  logic                            SCLK;
  logic                            DIN;

  modport master (
    output PowerDown, Speed, DacData,
    output LoadMask, LoadStart,
    input  Busy, LoadDone, Overrun,
    input  nCS, SCLK, DIN
  );

  modport slave (
    input  PowerDown, Speed, DacData,
    input  LoadMask, LoadStart,
    output Busy, LoadDone, Overrun,
    output nCS, SCLK, DIN
  );
endinterface

// File: rtl/dac_tlv5618_multi_loader.sv
// dac_tlv5618_multi_loader
// Serial loader for a bank of dual-channel TLV5618 DACs.
module dac_tlv5618_multi_loader #(
  parameter int NUM_DEV    = 2,
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input logic Clk,
  input logic reset_n,
  dac_tlv5618_multi_loader_if.slave bus
);
  localparam int F   = DATA_WIDTH + 4;
  localparam int NCH = 2 * NUM_DEV;
  localparam int XW  =
    (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int DVW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW  = $clog2(F);
  localparam int GW  =
    (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DVW-1:0] DIV_LAST =
    DVW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(F - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, LOAD, SHIFT, GAP, DONE
  } state_t;

  state_t state_q, state_d;

  logic [NCH*DATA_WIDTH-1:0] data_q;
  logic [NCH-1:0]            mask_q;
  logic                      spd_q;
  logic                      pwr_q;
  logic [XW-1:0]             dev_q;
  logic [F-1:0]              sreg_q;
  logic [DVW-1:0]            div_q;
  logic                      ph_q;
  logic [BW-1:0]             bit_q;
  logic [GW-1:0]             gap_q;

  logic [NUM_DEV-1:0] nCS_q, nCS_d;
  logic               SCLK_q, SCLK_d;
  logic               DIN_q, DIN_d;
  logic               LoadDone_q, LoadDone_d;
  logic               Overrun_q, Overrun_d;

  logic                  sel_found;
  logic [XW-1:0]         sel_dev;
  logic [1:0]            cur_m;
  logic [DATA_WIDTH-1:0] code_a;
  logic [DATA_WIDTH-1:0] code_b;
  logic [F-1:0]          word_d;
  logic                  shift_end;
  logic                  gap_end;

  assign cur_m  = mask_q[2*dev_q +: 2];
  assign code_a =
    data_q[(2*dev_q)*DATA_WIDTH +: DATA_WIDTH];
  assign code_b =
    data_q[(2*dev_q+1)*DATA_WIDTH +: DATA_WIDTH];

  assign shift_end = ph_q
    && (div_q == DIV_LAST)
    && (bit_q == BIT_LAST);
  assign gap_end = (gap_q == GAP_LAST);

  // Lowest device that still has a channel pending
  always_comb begin
    sel_found = 1'b0;
    sel_dev   = '0;
    for (int d = NUM_DEV - 1; d >= 0; d--) begin
      if (|mask_q[2*d +: 2]) begin
        sel_found = 1'b1;
        sel_dev   = XW'(d);
      end
    end
  end

  // Frame word: B goes to the buffer first when both are due
  always_comb begin
    unique case (1'b1)
      (cur_m == 2'b11):
        word_d = {1'b0, spd_q, pwr_q, 1'b1, code_b};
      (cur_m == 2'b01):
        word_d = {1'b1, spd_q, pwr_q, 1'b0, code_a};
      default:
        word_d = {1'b0, spd_q, pwr_q, 1'b0, code_b};
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.LoadStart) state_d = SELECT;
      SELECT: state_d = sel_found ? LOAD : DONE;
      LOAD:   state_d = SHIFT;
      SHIFT:  if (shift_end) state_d = GAP;
      GAP:
        if (gap_end)
          state_d = (|cur_m) ? LOAD : SELECT;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered one cycle behind state
  always_comb begin
    nCS_d      = '1;
    SCLK_d     = 1'b1;
    DIN_d      = 1'b0;
    LoadDone_d = (state_q == DONE);
    Overrun_d  = bus.LoadStart && (state_q != IDLE);
    if (state_q == SHIFT) begin
      nCS_d[dev_q] = 1'b0;
      SCLK_d       = ~ph_q;
      DIN_d        = sreg_q[F-1];
    end
  end

  // Output registers
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      nCS_q      <= '1;
      SCLK_q     <= 1'b1;
      DIN_q      <= 1'b0;
      LoadDone_q <= 1'b0;
      Overrun_q  <= 1'b0;
    end else begin
      nCS_q      <= nCS_d;
      SCLK_q     <= SCLK_d;
      DIN_q      <= DIN_d;
      LoadDone_q <= LoadDone_d;
      Overrun_q  <= Overrun_d;
    end
  end

  // Request latch, frame shifter and timing counters
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      mask_q <= '0;
      spd_q  <= 1'b0;
      pwr_q  <= 1'b0;
      dev_q  <= '0;
      sreg_q <= '0;
      div_q  <= '0;
      ph_q   <= 1'b0;
      bit_q  <= '0;
      gap_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.LoadStart) begin
            data_q <= bus.DacData;
            mask_q <= bus.LoadMask;
            spd_q  <= bus.Speed;
            pwr_q  <= bus.PowerDown;
          end
        end
        SELECT: dev_q <= sel_dev;
        LOAD: begin
          sreg_q <= word_d;
          div_q  <= '0;
          ph_q   <= 1'b0;
          bit_q  <= '0;
          if (cur_m[1]) mask_q[2*dev_q+1] <= 1'b0;
          else          mask_q[2*dev_q]   <= 1'b0;
        end
        SHIFT: begin
          gap_q <= '0;
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            ph_q  <= ~ph_q;
            if (ph_q) begin
              sreg_q <= {sreg_q[F-2:0], 1'b0};
              bit_q  <= bit_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        GAP: gap_q <= gap_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.Busy     = (state_q != IDLE);
  assign bus.LoadDone = LoadDone_q;
  assign bus.Overrun  = Overrun_q;
  assign bus.nCS      = nCS_q;
  assign bus.SCLK     = SCLK_q;
  assign bus.DIN      = DIN_q;

endmodule

// File: tb/tb_dac_tlv5618_multi_loader.sv
// tb_dac_tlv5618_multi_loader
// Directed bench for the TLV5618 multi-device loader.
module tb_dac_tlv5618_multi_loader;
  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 Clk = ~Clk;

  dac_tlv5618_multi_loader_if #(
    .NUM_DEV(2), .DATA_WIDTH(12)
  ) bus ();

  dac_tlv5618_multi_loader #(
    .NUM_DEV(2), .DATA_WIDTH(12),
    .CLK_DIV(2), .CS_GAP(2)
  ) dut (
    .Clk(Clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [15:0] mon_sr = '0;
  int mon_bits = 0;
  int sclk_falls = 0;
  int multi_low = 0;
  logic [1:0] prev_ncs = 2'b11;
  logic prev_busy = 1'b0;
  int f_dev[$];
  logic [15:0] f_word[$];
  int f_bits[$];
  int fall_c[$], rise_c[$], done_c[$];
  int ovr_c[$], bfall_c[$];

  // DAC side: capture DIN on falling SCLK
  always @(negedge bus.SCLK) begin
    mon_sr = {mon_sr[14:0], bus.DIN};
    mon_bits++;
    sclk_falls++;
  end

  // Event log, sampled 1 ns after each clock edge
  always @(posedge Clk) begin
    #1;
    if (!$onehot0(~bus.nCS)) multi_low++;
    for (int d = 0; d < 2; d++) begin
      if (prev_ncs[d] && !bus.nCS[d]) begin
        fall_c.push_back(cyc);
        mon_bits = 0;
      end
      if (!prev_ncs[d] && bus.nCS[d] && reset_n) begin
        rise_c.push_back(cyc);
        f_dev.push_back(d);
        f_word.push_back(mon_sr);
        f_bits.push_back(mon_bits);
      end
    end
    if (bus.LoadDone) done_c.push_back(cyc);
    if (bus.Overrun) ovr_c.push_back(cyc);
    if (prev_busy && !bus.Busy) bfall_c.push_back(cyc);
    prev_ncs = bus.nCS;
    prev_busy = bus.Busy;
  end

  task automatic clr();
    f_dev.delete(); f_word.delete(); f_bits.delete();
    fall_c.delete(); rise_c.delete(); done_c.delete();
    ovr_c.delete(); bfall_c.delete();
  endtask

  // Issue one request; e0 is the accepting edge. Inputs are
  // scrambled right after acceptance.
  task automatic req(input logic [3:0] m,
                     input logic [47:0] d,
                     input logic spd, input logic pwr,
                     output int e0);
    clr();
    @(negedge Clk);
    bus.LoadMask = m; bus.DacData = d;
    bus.Speed = spd; bus.PowerDown = pwr;
    bus.LoadStart = 1'b1;
    @(posedge Clk); #2;
    e0 = cyc;
    bus.LoadStart = 1'b0;
    bus.LoadMask = ~m; bus.DacData = ~d;
    bus.Speed = ~spd; bus.PowerDown = ~pwr;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_c.size() == 0 && n < 400) begin
      @(posedge Clk); #2; n++;
    end
    checks++;
    if (done_c.size() == 0) begin
      errors++;
      $display("FAIL %s_timeout: no LoadDone in 400 cycles", nm);
    end
    repeat (4) @(posedge Clk);
    #2;
  endtask

  task automatic test_reset();
    logic [6:0] v;
    bus.LoadStart = 0; bus.LoadMask = 0; bus.DacData = 0;
    bus.Speed = 0; bus.PowerDown = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge Clk); #2;
    v = {bus.Busy, bus.LoadDone, bus.Overrun, bus.nCS, bus.SCLK, bus.DIN};
    checks++;
    if (v !== 7'b0001110) begin errors++; $display("FAIL reset_outs: got %b want 0001110", v); end
    @(negedge Clk) reset_n = 1'b1;
    repeat (2) @(posedge Clk); #2;
    v = {bus.Busy, bus.LoadDone, bus.Overrun, bus.nCS, bus.SCLK, bus.DIN};
    checks++;
    if (v !== 7'b0001110) begin errors++; $display("FAIL idle_outs: got %b want 0001110", v); end
  endtask

  task automatic test_single_a();
    int e0;
    req(4'b0001, {36'h0, 12'hABC}, 1'b1, 1'b0, e0);
    checks++;
    if (bus.Busy !== 1'b1) begin errors++; $display("FAIL busy_set: got %b want 1", bus.Busy); end
    wait_done("single_a");
    checks++;
    if (f_word.size() !== 1) begin errors++; $display("FAIL sa_nframes: got %0d want 1", f_word.size()); end
    checks++;
    if (f_dev[0] !== 0) begin errors++; $display("FAIL sa_dev: got %0d want 0", f_dev[0]); end
    checks++;
    if (f_word[0] !== 16'hCABC) begin errors++; $display("FAIL sa_word: got %h want cabc", f_word[0]); end
    checks++;
    if (f_bits[0] !== 16) begin errors++; $display("FAIL sa_bits: got %0d want 16", f_bits[0]); end
    checks++;
    if (fall_c[0] - e0 !== 3) begin errors++; $display("FAIL sa_fall: got %0d want 3", fall_c[0] - e0); end
    checks++;
    if (rise_c[0] - e0 !== 67) begin errors++; $display("FAIL sa_rise: got %0d want 67", rise_c[0] - e0); end
    checks++;
    if (done_c[0] - e0 !== 70) begin errors++; $display("FAIL sa_done: got %0d want 70", done_c[0] - e0); end
    checks++;
    if (done_c.size() !== 1) begin errors++; $display("FAIL sa_done_pulses: got %0d want 1", done_c.size()); end
    checks++;
    if (bfall_c[0] !== done_c[0]) begin errors++; $display("FAIL sa_busy_drop: got %0d want %0d", bfall_c[0], done_c[0]); end
  endtask

  task automatic test_both();
    int e0;
    req(4'b0011, {24'h0, 12'h123, 12'h456}, 1'b0, 1'b0, e0);
    wait_done("both");
    checks++;
    if (f_word.size() !== 2) begin errors++; $display("FAIL bo_nframes: got %0d want 2", f_word.size()); end
    checks++;
    if ({f_word[0], f_word[1]} !== 32'h1123_8456) begin
      errors++; $display("FAIL bo_words: got %h %h want 1123 8456", f_word[0], f_word[1]);
    end
    checks++;
    if (f_dev[0] + f_dev[1] !== 0) begin errors++; $display("FAIL bo_dev: got %0d %0d want 0 0", f_dev[0], f_dev[1]); end
    checks++;
    if (fall_c[1] - rise_c[0] !== 3) begin errors++; $display("FAIL bo_gap: got %0d want 3", fall_c[1] - rise_c[0]); end
    checks++;
    if (done_c[0] - e0 !== 137) begin errors++; $display("FAIL bo_done: got %0d want 137", done_c[0] - e0); end
  endtask

  task automatic test_dev1_b();
    int e0;
    req(4'b1000, {12'h0FF, 36'h0}, 1'b0, 1'b1, e0);
    wait_done("dev1_b");
    checks++;
    if (f_word.size() !== 1) begin errors++; $display("FAIL d1_nframes: got %0d want 1", f_word.size()); end
    checks++;
    if (f_dev[0] !== 1) begin errors++; $display("FAIL d1_dev: got %0d want 1", f_dev[0]); end
    checks++;
    if (f_word[0] !== 16'h20FF) begin errors++; $display("FAIL d1_word: got %h want 20ff", f_word[0]); end
    checks++;
    if (fall_c[0] - e0 !== 3) begin errors++; $display("FAIL d1_fall: got %0d want 3", fall_c[0] - e0); end
  endtask

  task automatic test_back_to_back();
    int e0, x, dv;
    req(4'b1111, {12'hCBA, 12'h987, 12'h654, 12'h321}, 1'b1, 1'b1, e0);
    repeat (40) @(posedge Clk);
    @(negedge Clk);
    bus.LoadMask = 4'b0001; bus.LoadStart = 1'b1;
    @(posedge Clk); #2;
    x = cyc;
    bus.LoadStart = 1'b0;
    wait_done("all");
    checks++;
    if (ovr_c.size() !== 1) begin errors++; $display("FAIL ov_pulses: got %0d want 1", ovr_c.size()); end
    checks++;
    if (ovr_c[0] !== x) begin errors++; $display("FAIL ov_cycle: got %0d want %0d", ovr_c[0], x); end
    checks++;
    if (f_word.size() !== 4) begin errors++; $display("FAIL al_nframes: got %0d want 4", f_word.size()); end
    checks++;
    if ({f_word[0], f_word[1], f_word[2], f_word[3]} !== 64'h7654_E321_7CBA_E987) begin
      errors++;
      $display("FAIL al_words: got %h %h %h %h want 7654 e321 7cba e987",
               f_word[0], f_word[1], f_word[2], f_word[3]);
    end
    dv = f_dev[0]*8 + f_dev[1]*4 + f_dev[2]*2 + f_dev[3];
    checks++;
    if (dv !== 3) begin errors++; $display("FAIL al_devs: got %0d want 3", dv); end
    checks++;
    if (fall_c[2] - rise_c[1] !== 4) begin errors++; $display("FAIL al_devgap: got %0d want 4", fall_c[2] - rise_c[1]); end
    checks++;
    if (done_c[0] - e0 !== 272) begin errors++; $display("FAIL al_done: got %0d want 272", done_c[0] - e0); end
  endtask

  task automatic test_zero();
    int e0, s0;
    s0 = sclk_falls;
    req(4'b0000, 48'h123456789ABC, 1'b1, 1'b0, e0);
    wait_done("zero");
    checks++;
    if (done_c[0] - e0 !== 2) begin errors++; $display("FAIL z_done: got %0d want 2", done_c[0] - e0); end
    checks++;
    if (sclk_falls !== s0) begin errors++; $display("FAIL z_sclk: got %0d want %0d", sclk_falls, s0); end
    checks++;
    if (fall_c.size() !== 0) begin errors++; $display("FAIL z_ncs: got %0d want 0", fall_c.size()); end
    checks++;
    if (bfall_c[0] !== done_c[0]) begin errors++; $display("FAIL z_busy: got %0d want %0d", bfall_c[0], done_c[0]); end
  endtask

  task automatic test_reset_mid();
    int e0, e1;
    logic [6:0] v;
    req(4'b0001, {36'h0, 12'h777}, 1'b0, 1'b0, e0);
    repeat (23) @(posedge Clk);
    #2;
    checks++;
    if (bus.nCS !== 2'b10) begin errors++; $display("FAIL rm_active: got %b want 10", bus.nCS); end
    @(negedge Clk) reset_n = 1'b0;
    #1;
    v = {bus.Busy, bus.LoadDone, bus.Overrun, bus.nCS, bus.SCLK, bus.DIN};
    checks++;
    if (v !== 7'b0001110) begin errors++; $display("FAIL rm_outs: got %b want 0001110", v); end
    repeat (2) @(posedge Clk);
    @(negedge Clk) reset_n = 1'b1;
    repeat (5) @(posedge Clk);
    #2;
    checks++;
    if (done_c.size() !== 0) begin errors++; $display("FAIL rm_nodone: got %0d want 0", done_c.size()); end
    req(4'b0010, {24'h0, 12'h5A5, 12'h0}, 1'b0, 1'b0, e1);
    wait_done("after_reset");
    checks++;
    if (f_word[0] !== 16'h05A5) begin errors++; $display("FAIL rm_word: got %h want 05a5", f_word[0]); end
    checks++;
    if (done_c[0] - e1 !== 70) begin errors++; $display("FAIL rm_done: got %0d want 70", done_c[0] - e1); end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_both();
    test_dev1_b();
    test_back_to_back();
    test_zero();
    test_reset_mid();
    checks++;
    if (multi_low !== 0) begin errors++; $display("FAIL onehot_ncs: got %0d want 0", multi_low); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
